// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: header geometry, header type and the inserter FSM states.
package eth_pkg;

  localparam int ETH_HDR_BYTES       = 14;
  localparam int ETH_MIN_FRAME_BYTES = 60;

  typedef logic [ETH_HDR_BYTES-1:0][7:0] eth_hdr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2,
    PAD  = 2'd3
  } ins_state_e;

endpackage

// File: rtl/eth_header_inserter_if.sv
// Byte-wide AXI-Stream bundle; master drives data/valid/last, slave drives ready.
interface eth_header_inserter_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_byte_out_reg.sv
// Registered AXI-Stream byte output stage; a new byte enters only when the slot is free or draining.
module axis_byte_out_reg (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         load,
  eth_header_inserter_if.master        m_axis
);

  assign load = !m_axis.tvalid || m_axis.tready;

  // Output register: refill on load, otherwise hold the stalled byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= 8'h00;
      m_axis.tlast  <= 1'b0;
    end else if (load) begin
      m_axis.tvalid <= in_valid;
      if (in_valid) begin
        m_axis.tdata <= in_data;
        m_axis.tlast <= in_last;
      end
    end
  end

endmodule

// File: rtl/eth_header_inserter.sv
// Serialises a parallel Ethernet header ahead of a byte-wide payload stream, zero-padding short frames.
module eth_header_inserter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int HEADER_BYTES    = ETH_HDR_BYTES,
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
  parameter int PAD_ENABLE      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [HEADER_BYTES-1:0][7:0] hdr_bytes,
  input  logic                         hdr_valid,
  output logic                         hdr_ready,
  eth_header_inserter_if.slave         s_axis,
  eth_header_inserter_if.master        m_axis,
  output logic                         busy
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_header_inserter: DATA_WIDTH must be 8");
  end

  localparam int CNT_W = $clog2(MIN_FRAME_BYTES + 1);
  localparam int IDX_W = $clog2(HEADER_BYTES);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEADER_BYTES - 1);

  ins_state_e                   state_r;
  logic [HEADER_BYTES-1:0][7:0] hdr_r;
  logic [IDX_W-1:0]             hdr_idx_r;
  logic [CNT_W-1:0]             byte_cnt_r;

  logic             load_s;
  logic             pay_hs_s;
  logic             pad_short_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             out_valid_s;
  logic [7:0]       out_data_s;
  logic             out_last_s;

  assign hdr_ready     = (state_r == IDLE);
  assign s_axis.tready = (state_r == PAY) && load_s;
  assign busy          = (state_r != IDLE) || m_axis.tvalid;
  assign pay_hs_s      = s_axis.tvalid && s_axis.tready;
  // Saturating so oversized payloads never wrap back into the padding range.
  assign cnt_inc_s     = (byte_cnt_r >= MIN_CNT) ? MIN_CNT : byte_cnt_r + CNT_W'(1);
  assign pad_short_s   = (PAD_ENABLE != 0) && (cnt_inc_s < MIN_CNT);

  // Next byte offered to the output register for the current state.
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    out_last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Byte 0 goes straight from the port so it appears the cycle after acceptance.
        out_valid_s = hdr_valid;
        out_data_s  = hdr_bytes[0];
      end
      HDR: begin
        out_valid_s = 1'b1;
        out_data_s  = hdr_r[hdr_idx_r];
      end
      PAY: begin
        out_valid_s = pay_hs_s;
        out_data_s  = s_axis.tdata;
        out_last_s  = s_axis.tlast && !pad_short_s;
      end
      PAD: begin
        out_valid_s = 1'b1;
        out_data_s  = 8'h00;
        out_last_s  = (cnt_inc_s >= MIN_CNT);
      end
      default: begin
        out_valid_s = 1'b0;
        out_data_s  = 8'h00;
        out_last_s  = 1'b0;
      end
    endcase
  end

  // Frame sequencing FSM with header latch, header index and frame byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hdr_r      <= '0;
      hdr_idx_r  <= '0;
      byte_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hdr_valid) begin
            hdr_r   <= hdr_bytes;
            state_r <= HDR;
            if (load_s) begin
              hdr_idx_r  <= IDX_W'(1);
              byte_cnt_r <= CNT_W'(1);
            end else begin
              hdr_idx_r  <= '0;
              byte_cnt_r <= '0;
            end
          end
        end
        HDR: begin
          if (load_s) begin
            hdr_idx_r  <= hdr_idx_r + IDX_W'(1);
            byte_cnt_r <= cnt_inc_s;
            if (hdr_idx_r == LAST_IDX) begin
              state_r <= PAY;
            end
          end
        end
        PAY: begin
          if (pay_hs_s) begin
            byte_cnt_r <= cnt_inc_s;
            if (s_axis.tlast) begin
              state_r <= pad_short_s ? PAD : IDLE;
            end
          end
        end
        PAD: begin
          if (load_s) begin
            byte_cnt_r <= cnt_inc_s;
            if (cnt_inc_s >= MIN_CNT) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  axis_byte_out_reg u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (out_valid_s),
    .in_data  (out_data_s),
    .in_last  (out_last_s),
    .load     (load_s),
    .m_axis   (m_axis)
  );

endmodule

// File: tb/tb_eth_header_inserter.sv
// Directed bench for eth_header_inserter: scoreboard of expected frame bytes plus stall/handshake checks.
module tb_eth_header_inserter;
  import eth_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  eth_hdr_t hdr_bytes;
  logic     hdr_valid;
  logic     hdr_ready;
  logic     busy;
  eth_hdr_t hdr_bytes_np;
  logic     hdr_valid_np;
  logic     hdr_ready_np;
  logic     busy_np;

  eth_header_inserter_if s_axis ();
  eth_header_inserter_if m_axis ();
  eth_header_inserter_if s_np ();
  eth_header_inserter_if m_np ();

  always #5 clk = ~clk;

  eth_header_inserter #(.DATA_WIDTH(8), .HEADER_BYTES(14), .MIN_FRAME_BYTES(60), .PAD_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .hdr_bytes(hdr_bytes), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .s_axis(s_axis), .m_axis(m_axis), .busy(busy)
  );

  eth_header_inserter #(.DATA_WIDTH(8), .HEADER_BYTES(14), .MIN_FRAME_BYTES(60), .PAD_ENABLE(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .hdr_bytes(hdr_bytes_np), .hdr_valid(hdr_valid_np), .hdr_ready(hdr_ready_np),
    .s_axis(s_np), .m_axis(m_np), .busy(busy_np)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] pay_q[$];
  bit         pay_en = 1'b0;
  bit         rand_ready = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l;
  int         frm_out = 0;
  int         frames = 0;
  int         last_len = 0;
  bit         hs_seen = 1'b0;
  bit         chk_bubbles = 1'b0;
  int         bubbles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_s();
    s_axis.tvalid = pay_en && (pay_q.size() > 0);
    {s_axis.tlast, s_axis.tdata} = (pay_q.size() > 0) ? pay_q[0] : 9'h000;
  endtask

  // One clock of the main DUT: observe before the rising edge, re-drive after the falling edge.
  task automatic tick();
    logic [8:0] e;
    #1;
    if (stall_prev) begin
      check("stall_data", {24'h0, m_axis.tdata}, {24'h0, hold_d});
      check("stall_last", {31'h0, m_axis.tlast}, {31'h0, hold_l});
    end
    if (m_axis.tvalid && !m_axis.tready) begin
      check("stall_s_tready", {31'h0, s_axis.tready}, 32'h0);
      stall_prev = 1'b1;
      hold_d     = m_axis.tdata;
      hold_l     = m_axis.tlast;
    end else begin
      stall_prev = 1'b0;
    end
    if (s_axis.tready) begin
      check("early_pay", ((frm_out + int'(m_axis.tvalid)) >= 14) ? 32'h1 : 32'h0, 32'h1);
    end
    if (m_axis.tvalid && m_axis.tready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 32'h1);
      end else begin
        e = exp_q.pop_front();
        check("frame_byte", {23'h0, m_axis.tlast, m_axis.tdata}, {23'h0, e});
      end
      frm_out++;
      if (m_axis.tlast) begin
        frames++;
        last_len = frm_out;
        frm_out  = 0;
      end
    end
    if (chk_bubbles && busy && !m_axis.tvalid) bubbles++;
    if (hdr_valid && hdr_ready) hs_seen = 1'b1;
    if (s_axis.tvalid && s_axis.tready) void'(pay_q.pop_front());
    @(negedge clk);
    m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_s();
  endtask

  function automatic eth_hdr_t make_hdr(input logic [7:0] base);
    eth_hdr_t h;
    for (int i = 0; i < 14; i++) h[i] = 8'(base + 8'(i));
    return h;
  endfunction

  // Expected frame from the header, payload and padding rules; payload is queued for the driver.
  task automatic queue_frame(input eth_hdr_t h, input int n, input bit rnd, input logic [7:0] base, input bit pad);
    logic [7:0] b;
    int         total;
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, h[i]});
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(base + 8'(i));
      pay_q.push_back({(i == n - 1), b});
      exp_q.push_back({1'b0, b});
    end
    total = 14 + n;
    while (pad && total < 60) begin
      exp_q.push_back(9'h000);
      total++;
    end
    exp_q[exp_q.size() - 1][8] = 1'b1;
  endtask

  task automatic send_hdr(input eth_hdr_t h);
    hdr_bytes = h;
    hdr_valid = 1'b1;
    hs_seen   = 1'b0;
    for (int i = 0; i < 200 && !hs_seen; i++) tick();
    hdr_valid = 1'b0;
    hdr_bytes = ~h;
    check("hdr_handshake", {31'h0, hs_seen}, 32'h1);
  endtask

  task automatic run_frames(input int target, input int budget);
    for (int i = 0; i < budget && frames < target; i++) tick();
    check("frame_done", (frames >= target) ? 32'h1 : 32'h0, 32'h1);
  endtask

  initial begin
    eth_hdr_t   h;
    int         cnt;
    bit         done;
    bit         hv;
    bit         sv;
    logic [8:0] np_exp;

    hdr_valid = 1'b0; hdr_bytes = '0;
    hdr_valid_np = 1'b0; hdr_bytes_np = '0;
    m_axis.tready = 1'b1; m_np.tready = 1'b1;
    s_np.tvalid = 1'b0; s_np.tdata = 8'h00; s_np.tlast = 1'b0;
    drive_s();
    @(negedge clk); @(negedge clk);
    check("rst_hdr_ready", {31'h0, hdr_ready}, 32'h1);
    check("rst_s_tready", {31'h0, s_axis.tready}, 32'h0);
    check("rst_m_tvalid", {31'h0, m_axis.tvalid}, 32'h0);
    check("rst_m_tlast", {31'h0, m_axis.tlast}, 32'h0);
    check("rst_m_tdata", {24'h0, m_axis.tdata}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;

    // Full-size frame with payload offered before the header.
    h = make_hdr(8'h00);
    queue_frame(h, 46, 1'b0, 8'h10, 1'b1);
    pay_en = 1'b1;
    drive_s();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("early_tready_low", {31'h0, s_axis.tready}, 32'h0);
    end
    bubbles = 0;
    chk_bubbles = 1'b1;
    send_hdr(h);
    #1;
    check("latency_valid", {31'h0, m_axis.tvalid}, 32'h1);
    check("latency_byte0", {24'h0, m_axis.tdata}, {24'h0, h[0]});
    run_frames(frames + 1, 200);
    chk_bubbles = 1'b0;
    check("t1_len", last_len, 32'd60);
    check("t1_bubbles", bubbles, 32'd0);
    check("t1_payload_drained", pay_q.size(), 32'd0);

    // One-byte payload padded out to the minimum length.
    h = make_hdr(8'hA0);
    queue_frame(h, 1, 1'b0, 8'hAA, 1'b1);
    drive_s();
    send_hdr(h);
    run_frames(frames + 1, 200);
    check("t2_len", last_len, 32'd60);

    // Long random payload under random downstream back-pressure.
    rand_ready = 1'b1;
    h = make_hdr(8'h40);
    queue_frame(h, 100, 1'b1, 8'h00, 1'b1);
    drive_s();
    send_hdr(h);
    run_frames(frames + 1, 2000);
    check("t3_len", last_len, 32'd114);
    check("t3_sb_empty", exp_q.size(), 32'd0);
    rand_ready = 1'b0;
    m_axis.tready = 1'b1;

    // Padding disabled: header plus single byte, tlast on the payload byte.
    h = make_hdr(8'h70);
    hdr_bytes_np = h; hdr_valid_np = 1'b1;
    s_np.tdata = 8'hAA; s_np.tlast = 1'b1; s_np.tvalid = 1'b1;
    cnt = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      hv = hdr_valid_np && hdr_ready_np;
      sv = s_np.tvalid && s_np.tready;
      if (m_np.tvalid) begin
        np_exp = (cnt < 14) ? {1'b0, h[cnt]} : 9'h1AA;
        check("np_byte", {23'h0, m_np.tlast, m_np.tdata}, {23'h0, np_exp});
        cnt++;
        done = m_np.tlast;
      end
      @(negedge clk);
      if (hv) hdr_valid_np = 1'b0;
      if (sv) s_np.tvalid = 1'b0;
    end
    check("np_len", cnt, 32'd15);

    // Reset in the middle of the payload, then a clean frame.
    h = make_hdr(8'hC0);
    queue_frame(h, 100, 1'b1, 8'h00, 1'b1);
    drive_s();
    send_hdr(h);
    for (int i = 0; i < 25; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", {31'h0, m_axis.tvalid}, 32'h0);
    check("mid_rst_tlast", {31'h0, m_axis.tlast}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_hdr_ready", {31'h0, hdr_ready}, 32'h1);
    check("mid_rst_s_tready", {31'h0, s_axis.tready}, 32'h0);
    exp_q.delete();
    pay_q.delete();
    frm_out = 0;
    stall_prev = 1'b0;
    drive_s();
    @(negedge clk);
    rst_n = 1'b1;
    h = make_hdr(8'hE0);
    queue_frame(h, 46, 1'b0, 8'h80, 1'b1);
    drive_s();
    send_hdr(h);
    run_frames(frames + 1, 200);
    check("t5_len", last_len, 32'd60);
    check("t5_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_header_inserter.md
# eth_header_inserter

Transmit-side counterpart of the header capture logic. Accepts a parallel 14-byte Ethernet header (destination MAC, source MAC, EtherType) and a byte-wide AXI-Stream payload, and emits one byte-serial AXI-Stream frame: header bytes first, then payload. Frames shorter than the Ethernet minimum are optionally zero-padded. The block sits between the frame builder and the MAC TX path.

## Interface
- DATA_WIDTH, 8, stream width in bits; only 8 is legal, elaboration error otherwise
- HEADER_BYTES, 14, header length in bytes
- MIN_FRAME_BYTES, 60, minimum frame length excluding FCS, counted as header plus payload
- PAD_ENABLE, 1, when 1, short frames are zero-padded to MIN_FRAME_BYTES
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- hdr_bytes  in  [HEADER_BYTES-1:0][7:0]  header; index 0 is the first byte on the wire
- hdr_valid  in  1  header offered
- hdr_ready  out  1  header accepted when hdr_valid && hdr_ready
- s_axis_tdata  in  8  payload byte
- s_axis_tvalid  in  1  payload valid
- s_axis_tlast  in  1  last payload byte
- s_axis_tready  out  1  payload accept
- m_axis_tdata  out  8  frame byte
- m_axis_tvalid  out  1  frame byte valid
- m_axis_tlast  out  1  last frame byte
- m_axis_tready  in  1  downstream accept
- busy  out  1  high while state != IDLE or m_axis_tvalid

## Operation
- FSM has four states: IDLE, HDR, PAY, PAD.
- **IDLE**
  - hdr_ready = 1.
  - On a hdr_valid handshake: latch hdr_bytes, clear hdr_idx and byte_cnt, go to HDR.
- **Output register**
  - m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered.
  - Define load = !m_axis_tvalid || m_axis_tready.
  - A new byte enters the register only on a cycle where load is high.
  - If load is high and no byte is available, m_axis_tvalid clears.
- **HDR**
  - On each load, emit hdr_bytes[hdr_idx] with tlast = 0, then increment hdr_idx and byte_cnt.
  - After byte HEADER_BYTES-1 is loaded, go to PAY.
- **PAY**
  - s_axis_tready = load.
  - Each payload handshake copies tdata into the output register and increments byte_cnt.
  - On the handshake that carries s_axis_tlast:
    - If PAD_ENABLE and byte_cnt+1 < MIN_FRAME_BYTES: emit the byte with tlast = 0 and go to PAD.
    - Otherwise: emit the byte with tlast = 1 and go to IDLE.
- **PAD**
  - On each load, emit 8'h00 and increment byte_cnt.
  - The byte that brings byte_cnt to MIN_FRAME_BYTES carries tlast = 1; then go to IDLE.
- **Byte counter**
  - byte_cnt width is $clog2(MIN_FRAME_BYTES+1).
  - It saturates at MIN_FRAME_BYTES, so long payloads never wrap it.
- s_axis_tready = 0 in every state other than PAY. Payload offered early is back-pressured.
- The latched header is stable from acceptance until the next IDLE handshake. Changes on hdr_bytes after acceptance have no effect.

## Timing
- **Reset values:** state = IDLE, hdr_ready = 1, s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, busy = 0.
- **Latency:** header handshake in cycle N puts byte 0 on m_axis in cycle N+1.
- **Throughput:** with m_axis_tready held high and the payload always valid, the stream runs one byte per cycle with no bubbles between HDR, PAY and PAD.
- **Between frames:** exactly one IDLE cycle. The next header can be accepted in the same cycle that the final byte of the current frame is still waiting in the output register.
- **Back-pressure:** while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast hold stable and s_axis_tready = 0.
- **Reset mid-frame:** all outputs return to their reset values asynchronously. The partial frame is dropped and no tlast is emitted.

## Structure
- Shared package eth_pkg holds:
  - ETH_HDR_BYTES = 14 and ETH_MIN_FRAME_BYTES = 60
  - eth_hdr_t, a packed [13:0][7:0] array
  - the FSM state enum ins_state_e {IDLE, HDR, PAY, PAD}
- One sub-module, axis_byte_out_reg, holds the output register and load logic. It is reusable by other TX blocks.

## Test plan
- **Back-to-back header:** header 00..0D, 46-byte payload 0x10..0x3D, m_axis_tready=1 -> 60 bytes out, first byte in the cycle after the handshake, tlast only on byte 59, no padding, no bubbles.
- **Short frame padding:** 1-byte payload 0xAA, PAD_ENABLE=1 -> 14 header bytes, 0xAA, 45 zeros; tlast on byte 59; byte_cnt=60.
- **Padding disabled:** same stimulus with PAD_ENABLE=0 -> 15 bytes out, tlast on 0xAA.
- **Random back-pressure:** m_axis_tready toggled randomly (50%), 100-byte payload -> output equals header+payload exactly; data and tlast stable while stalled; s_axis_tready=0 during stalls.
- **Early payload:** s_axis_tvalid asserted before the header -> s_axis_tready=0 until byte 13 is loaded; no payload byte is lost or reordered.
- **Reset mid-frame:** rst_n asserted during PAY -> m_axis_tvalid=0 immediately, hdr_ready=1 after release; a following 60-byte frame is emitted correctly.
